// File: rtl/alu_rf_sequencer.sv
// Multi-cycle ALU sequencer: reads two operands from a 4x4 register file, executes one
// operation and writes the result back, one instruction per five cycles.
module alu_rf_sequencer #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rd_dst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] rf_rd1,
  output logic [ADDR_W-1:0] rf_rd2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  output logic [ADDR_W-1:0] rf_wr,
  output logic              rf_write_enable,
  output logic [DATA_W-1:0] rf_data_in,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StRead, StExec, StWrite, StDone} state_e;
  typedef enum logic [2:0] {
    OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNot, OpShl, OpLdi
  } opcode_e;

  state_e              state_q, state_d;
  opcode_e             op_q;
  logic [ADDR_W-1:0]   rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0]   imm_q, a_q, b_q;
  logic [DATA_W-1:0]   result_q, alu_res;
  logic                carry_q, zero_q, alu_c;
  logic [DATA_W:0]     sum;
  logic                accept;

  assign accept = (state_q == StIdle) && instr_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (instr_valid) state_d = StRead;
      StRead:  state_d = StExec;
      StExec:  state_d = StWrite;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    sum     = '0;
    unique case (op_q)
      OpAdd: begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OpSub: begin
        alu_res = a_q - b_q;
        alu_c   = a_q < b_q;
      end
      OpAnd: alu_res = a_q & b_q;
      OpOr:  alu_res = a_q | b_q;
      OpXor: alu_res = a_q ^ b_q;
      OpNot: alu_res = ~a_q;
      OpShl: begin
        alu_res = {a_q[DATA_W-2:0], 1'b0};
        alu_c   = a_q[DATA_W-1];
      end
      OpLdi: alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= opcode_e'(opcode);
        rd_q  <= rd_dst;
        rs1_q <= rs1;
        rs2_q <= rs2;
        imm_q <= imm;
      end
      if (state_q == StRead) begin
        a_q <= rf_data1;
        b_q <= rf_data2;
      end
      if (state_q == StExec) begin
        result_q <= alu_res;
        carry_q  <= alu_c;
        zero_q   <= (alu_res == '0);
      end
    end
  end

  // Ready is gated by reset directly so it reads 0 while reset is held.
  assign instr_ready     = reset && (state_q == StIdle);
  assign rf_rd1          = rs1_q;
  assign rf_rd2          = rs2_q;
  assign rf_write_enable = (state_q == StWrite);
  assign rf_wr           = rf_write_enable ? rd_q : '0;
  assign rf_data_in      = rf_write_enable ? result_q : '0;
  assign result          = result_q;
  assign carry           = carry_q;
  assign zero            = zero_q;
  assign busy            = (state_q != StIdle);
  assign done            = (state_q == StDone);

endmodule

// File: tb/tb_alu_rf_sequencer.sv
// Randomised bench for alu_rf_sequencer: a behavioural register file plus an arithmetic
// reference model predict every write-back, flag and handshake cycle.
module tb_alu_rf_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] opcode;
  logic [1:0] rd_dst, rs1, rs2;
  logic [3:0] imm;
  logic [1:0] rf_rd1, rf_rd2, rf_wr;
  logic [3:0] rf_data1, rf_data2, rf_data_in;
  logic       rf_write_enable;
  logic [3:0] result;
  logic       carry, zero, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [3:0] rf_mem [4];
  logic [3:0] m_rf   [4];

  always #5 clk = ~clk;

  alu_rf_sequencer #(.DATA_W(4), .ADDR_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .opcode         (opcode),
    .rd_dst         (rd_dst),
    .rs1            (rs1),
    .rs2            (rs2),
    .imm            (imm),
    .rf_rd1         (rf_rd1),
    .rf_rd2         (rf_rd2),
    .rf_data1       (rf_data1),
    .rf_data2       (rf_data2),
    .rf_wr          (rf_wr),
    .rf_write_enable(rf_write_enable),
    .rf_data_in     (rf_data_in),
    .result         (result),
    .carry          (carry),
    .zero           (zero),
    .busy           (busy),
    .done           (done)
  );

  // Register file: combinational reads, write on rising edge.
  assign rf_data1 = rf_mem[rf_rd1];
  assign rf_data2 = rf_mem[rf_rd2];
  always @(posedge clk) if (rf_write_enable) rf_mem[rf_wr] <= rf_data_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic rand_fields();
    opcode = 3'($urandom_range(0, 7));
    rd_dst = 2'($urandom_range(0, 3));
    rs1    = 2'($urandom_range(0, 3));
    rs2    = 2'($urandom_range(0, 3));
    imm    = 4'($urandom_range(0, 15));
  endtask

  // Entered and left at a falling edge with the sequencer idle.
  task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] r1,
                           input logic [1:0] r2, input logic [3:0] im, input bit hold,
                           input bit abort);
    int a, b, r, c;
    a = int'(m_rf[r1]);
    b = int'(m_rf[r2]);
    c = 0;
    case (op)
      3'd0: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
      3'd1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 15 - a;
      3'd6: begin r = (a * 2) % 16; c = (a >= 8) ? 1 : 0; end
      default: r = int'(im);
    endcase

    opcode = op; rd_dst = rd; rs1 = r1; rs2 = r2; imm = im;
    instr_valid = 1'b1;
    check_eq("ready_idle", instr_ready, 1);
    @(posedge clk);
    @(negedge clk);  // READ
    if (hold) rand_fields(); else instr_valid = 1'b0;
    check_eq("ready_read", instr_ready, 0);
    check_eq("busy_read", busy, 1);
    check_eq("we_read", rf_write_enable, 0);
    check_eq("rd1_addr", rf_rd1, r1);
    check_eq("rd2_addr", rf_rd2, r2);
    @(negedge clk);  // EXEC
    if (hold) rand_fields();
    check_eq("ready_exec", instr_ready, 0);
    check_eq("we_exec", rf_write_enable, 0);
    check_eq("rd1_hold", rf_rd1, r1);
    @(negedge clk);  // WRITE
    if (hold) rand_fields();
    check_eq("we_write", rf_write_enable, 1);
    check_eq("wr_addr", rf_wr, rd);
    check_eq("wr_data", rf_data_in, r);
    check_eq("result", result, r);
    check_eq("carry", carry, c);
    check_eq("zero", zero, (r == 0) ? 1 : 0);
    check_eq("done_write", done, 0);
    if (abort) begin
      #2 reset = 1'b0;
      instr_valid = 1'b0;
      #1;
      check_eq("abort_we", rf_write_enable, 0);
      check_eq("abort_ready", instr_ready, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_result", result, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("abort_idle_ready", instr_ready, 1);
      check_eq("abort_done", done, 0);
      check_eq("abort_rf_kept", rf_mem[rd], m_rf[rd]);
      return;
    end
    m_rf[rd] = 4'(r);
    @(negedge clk);  // DONE
    if (hold) rand_fields();
    check_eq("done_pulse", done, 1);
    check_eq("we_done", rf_write_enable, 0);
    check_eq("ready_done", instr_ready, 0);
    check_eq("busy_done", busy, 1);
    check_eq("rf_commit", rf_mem[rd], m_rf[rd]);
    @(negedge clk);  // IDLE
    check_eq("done_low", done, 0);
    check_eq("ready_back", instr_ready, 1);
    check_eq("busy_idle", busy, 0);
    check_eq("result_held", result, r);
  endtask

  initial begin
    reset = 1'b0;
    instr_valid = 1'b0;
    opcode = '0; rd_dst = '0; rs1 = '0; rs2 = '0; imm = '0;
    #3;
    check_eq("rst_ready", instr_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_we", rf_write_enable, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd1", rf_rd1, 0);
    check_eq("rst_result", result, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ready", instr_ready, 1);

    for (int i = 0; i < 4; i++) run_instr(3'd7, 2'(i), 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);

    run_instr(3'd7, 2'd0, 2'd0, 2'd0, 4'd3, 1'b0, 1'b0);
    run_instr(3'd7, 2'd1, 2'd0, 2'd0, 4'd5, 1'b0, 1'b0);
    run_instr(3'd0, 2'd2, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0);
    check_eq("add_3_5", rf_mem[2], 8);

    run_instr(3'd7, 2'd0, 2'd0, 2'd0, 4'hF, 1'b0, 1'b0);
    run_instr(3'd7, 2'd1, 2'd0, 2'd0, 4'h1, 1'b0, 1'b0);
    run_instr(3'd0, 2'd3, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0);
    check_eq("add_ovf_carry", carry, 1);
    run_instr(3'd1, 2'd3, 2'd1, 2'd0, 4'd0, 1'b0, 1'b0);
    check_eq("sub_borrow_val", rf_mem[3], 4'h2);
    run_instr(3'd1, 2'd3, 2'd0, 2'd1, 4'd0, 1'b0, 1'b0);
    check_eq("sub_val", rf_mem[3], 4'hE);

    run_instr(3'd7, 2'd0, 2'd0, 2'd0, 4'hA, 1'b0, 1'b0);
    run_instr(3'd7, 2'd1, 2'd0, 2'd0, 4'h6, 1'b0, 1'b0);
    for (int op = 2; op <= 6; op++)
      run_instr(3'(op), 2'(2 + (op % 2)), 2'd0, 2'd1, 4'd0, 1'b0, 1'b0);

    run_instr(3'd7, 2'd1, 2'd0, 2'd0, 4'h7, 1'b0, 1'b0);
    run_instr(3'd0, 2'd1, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0);
    check_eq("src_eq_dst", rf_mem[1], 4'hE);

    for (int i = 0; i < 40; i++)
      run_instr(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'b0);
    instr_valid = 1'b0;

    run_instr(3'd7, 2'd3, 2'd0, 2'd0, ~m_rf[3], 1'b0, 1'b1);
    run_instr(3'd0, 2'd2, 2'd3, 2'd1, 4'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_rf_sequencer.md
Name: alu_rf_sequencer

Overview:
- Multi-cycle controller that drives the 4x4 register file's access ports: the initiator/master side of the file's read/write interface.
- Accepts one ALU instruction per valid/ready handshake.
- Reads two operands through the file's dual read ports, executes a 4-bit ALU operation, writes the result back through the write port, then pulses done.
- Sits between the instruction source (bench or future fetch unit) and the register file.

Parameters:
- DATA_W, 4, register/operand width; must match register file data width.
- ADDR_W, 2, register address width; must match register file depth (2**ADDR_W = 4 entries).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately, regardless of clk).
- instr_valid  input  1  instruction fields valid.
- instr_ready  output  1  sequencer can accept an instruction.
- opcode  input  3  ALU operation (encoding below).
- rd_dst  input  ADDR_W  destination register.
- rs1  input  ADDR_W  source register A.
- rs2  input  ADDR_W  source register B.
- imm  input  DATA_W  immediate for LDI.
- rf_rd1  output  ADDR_W  to register file rd1.
- rf_rd2  output  ADDR_W  to register file rd2.
- rf_data1  input  DATA_W  from register file data_out1; combinational read.
- rf_data2  input  DATA_W  from register file data_out2; combinational read.
- rf_wr  output  ADDR_W  to register file wr.
- rf_write_enable  output  1  to register file write_enable.
- rf_data_in  output  DATA_W  to register file data_in.
- result  output  DATA_W  last computed result.
- carry  output  1  carry/borrow flag of last op.
- zero  output  1  result==0 flag of last op.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after write-back commits.

Behaviour:
- Opcodes:
  - 000 ADD A+B
  - 001 SUB A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 SHL A by 1
  - 111 LDI (result=imm; rs1/rs2 ignored)
- Arithmetic is modulo 2**DATA_W.
- carry rules:
  - ADD: carry-out.
  - SUB: borrow, i.e. 1 when A<B unsigned.
  - SHL: shifted-out MSB of A.
  - All other ops: 0.
- zero = (result==0) for every op, including LDI.
- FSM states IDLE, READ, EXEC, WRITE, DONE; one cycle each except IDLE.
- IDLE: instr_ready=1. When instr_valid&instr_ready at a rising edge, latch opcode/rd_dst/rs1/rs2/imm and go to READ. Instruction inputs are ignored in all other states.
- rf_rd1/rf_rd2 are driven from the latched rs1/rs2 in all states (0 after reset).
- READ: at the edge leaving READ, capture rf_data1/rf_data2 into operand registers A/B; go to EXEC.
- EXEC: at the edge leaving EXEC, register result, carry and zero; go to WRITE.
- WRITE: rf_write_enable=1, rf_wr=latched rd_dst, rf_data_in=result. The register file commits at the edge leaving WRITE; go to DONE.
- DONE: done=1 for exactly one cycle, rf_write_enable=0; go to IDLE.
- Latency and throughput:
  - Acceptance edge at T; write commits at edge T+3; done high during cycle T+3..T+4.
  - instr_ready high again from T+4. Next acceptance is no earlier than edge T+5, so throughput is one instruction per 5 cycles.
- rf_write_enable is high only in WRITE; never in any other state or during reset.
- rf_wr and rf_data_in are 0 outside WRITE.
- rs1/rs2 may equal rd_dst: operands are captured in READ, before write-back, so the old value is used.
- The next instruction reading the just-written register sees the new value, since there is no hazard under serialized operation.
- result, carry and zero hold their values until the next EXEC.
- Reset:
  - reset=0 forces IDLE and sets all outputs to 0, except instr_ready, which is 1 while reset=1 and IDLE.
  - reset asserted mid-operation (any state) aborts the instruction. rf_write_enable drops asynchronously with reset, so no partial write occurs. Register file contents are governed by the file's own reset.
- instr_valid held high through completion does not cause re-acceptance before IDLE.

Test Plan:
- LDI sequence: LDI r0=3, LDI r1=5, ADD r2=r0+r1 → write r2=8; result=8, carry=0, zero=0; done asserted exactly 4 cycles after the ADD acceptance edge (T+4 edge sample).
- Overflow/borrow:
  - r0=0xF, r1=0x1: ADD r3 → r3=0x0, carry=1, zero=1.
  - SUB r3=r1-r0 → r3=0x2, carry=1.
  - SUB r3=r0-r1 → 0xE, carry=0.
- Logic and shift: r0=0xA, r1=0x6 → AND=0x2, OR=0xE, XOR=0xC, NOT r0=0x5, SHL r0=0x4 with carry=1; read back each destination via rf_rd1.
- Source equals destination: r1=0x7, ADD r1=r1+r1 → r1=0xE; operands captured as 0x7, not 0xE.
- Handshake: instr_valid held high continuously with changing fields → instr_ready low for 4 cycles after each acceptance; exactly one write per 5 cycles; busy high in READ..DONE.
- Reset mid-op: assert reset=0 while in WRITE, asynchronously between edges → rf_write_enable falls immediately; target register unchanged after release; FSM in IDLE with instr_ready=1, done=0.
